// File: rtl/frog_input_conditioner.sv
// frog_input_conditioner: synchronises, debounces and edge-detects the four
// raw board switches, then issues queued presses one per cycle as move pulses
// in priority order up > down > left > right.
// Optional build macro FROG_INPUT_AUTO_REPEAT_EN adds hold-to-repeat timers.
module frog_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       switch1,
  input  logic       switch2,
  input  logic       switch3,
  input  logic       switch4,
  output logic       move_up,
  output logic       move_down,
  output logic       move_left,
  output logic       move_right,
  output logic [1:0] move_dir,
  output logic [3:0] held
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       w_raw;
  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [3:0]       r_db;
  logic [CNT_W-1:0] r_cnt [4];
  logic [3:0]       w_toggle;
  logic [3:0]       w_db_next;
  logic [3:0]       w_rise;
  logic [3:0]       w_rpt_set;
  logic [3:0]       w_set;
  logic [3:0]       r_pending;
  logic [3:0]       w_issue;
  logic [1:0]       w_dir;
  logic [3:0]       r_move;
  logic [1:0]       r_dir;

  assign w_raw = {switch4, switch3, switch2, switch1};

  // A level toggles once the sync output has disagreed for DEBOUNCE_CYCLES cycles
  always_comb begin
    w_toggle = '0;
    for (int i = 0; i < 4; i++) begin
      w_toggle[i] = (r_sync2[i] != r_db[i]) && (r_cnt[i] == CNT_LAST);
    end
    w_db_next = r_db ^ w_toggle;
    w_rise    = w_toggle & w_db_next;
  end

  // Two-flop synchronisers, per-switch debounce counters and debounced levels
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_db    <= w_db_next;
      for (int i = 0; i < 4; i++) begin
        if ((r_sync2[i] == r_db[i]) || w_toggle[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

`ifdef FROG_INPUT_AUTO_REPEAT_EN
  localparam int unsigned RPT_W = $clog2(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RPT_W-1:0] r_rpt [4];

  // Repeat request fires when a held level's timer reaches its last count
  always_comb begin
    w_rpt_set = '0;
    for (int i = 0; i < 4; i++) begin
      w_rpt_set[i] = r_db[i] && (r_rpt[i] == RPT_LAST);
    end
  end

  // Hold timers: first repeat after REPEAT_DELAY, then every REPEAT_PERIOD
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        r_rpt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!r_db[i]) begin
          r_rpt[i] <= '0;
        end else if (w_rpt_set[i]) begin
          r_rpt[i] <= RPT_RELOAD;
        end else begin
          r_rpt[i] <= r_rpt[i] + RPT_W'(1);
        end
      end
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign w_rpt_set    = '0;
`endif

  // Arbiter picks the lowest set pending bit (up has priority) and encodes it
  always_comb begin
    w_set   = w_rise | w_rpt_set;
    w_issue = r_pending & (~r_pending + 4'd1);
    w_dir   = 2'd0;
    if (w_issue[0]) begin
      w_dir = 2'd0;
    end else if (w_issue[1]) begin
      w_dir = 2'd1;
    end else if (w_issue[2]) begin
      w_dir = 2'd2;
    end else if (w_issue[3]) begin
      w_dir = 2'd3;
    end
  end

  // Pending queue (a new set beats a same-cycle issue) and registered move outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
      r_move    <= '0;
      r_dir     <= 2'd0;
    end else begin
      r_pending <= (r_pending & ~w_issue) | w_set;
      r_move    <= w_issue;
      if (|w_issue) begin
        r_dir <= w_dir;
      end
    end
  end

  assign move_up    = r_move[0];
  assign move_down  = r_move[1];
  assign move_left  = r_move[2];
  assign move_right = r_move[3];
  assign move_dir   = r_dir;
  assign held       = r_db;

endmodule
